// File: rtl/gpio_pkg.sv
// gpio_pkg: register map, bus widths and small helpers shared by the gpio_ctrl slice.
package gpio_pkg;

    localparam int GPIO_AW = 3;
    localparam int GPIO_DW = 16;

    // Register indices on the Wishbone I/O bus.
    typedef enum logic [GPIO_AW-1:0] {
        GPIO_IN       = 3'd0,
        GPIO_OUT      = 3'd1,
        GPIO_OUT_SET  = 3'd2,
        GPIO_OUT_CLR  = 3'd3,
        GPIO_IRQ_EN   = 3'd4,
        GPIO_IRQ_STAT = 3'd5,
        GPIO_EDGE     = 3'd6,
        GPIO_RSVD     = 3'd7
    } gpio_reg_e;

    // Expands the two byte enables into a 16-bit bit mask.
    function automatic logic [GPIO_DW-1:0] byte_mask(input logic [1:0] sel);
        return {{8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/gpio_debounce.sv
// gpio_debounce: two-flop synchroniser plus a tick-sampled debouncer shared by all input bits.
// A bit only commits to deb once two consecutive tick samples agree, so any pulse
// shorter than DEB_DIV clocks can never be seen at two ticks in a row.
module gpio_debounce
    import gpio_pkg::*;
#(
    parameter int N       = 8,
    parameter int DEB_DIV = 16
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] din,
    output logic [N-1:0] deb
);

    localparam int            CW      = $clog2(DEB_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_DIV - 1);

    logic [N-1:0]  sync_meta;
    logic [N-1:0]  sync;
    logic [N-1:0]  samp;
    logic [N-1:0]  agree;
    logic [CW-1:0] cnt;
    logic          tick;

    // Bring the asynchronous pins into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= '0;
            sync      <= '0;
        end else begin
            sync_meta <= din;
            sync      <= sync_meta;
        end
    end

    // Free-running prescaler; tick fires on its last count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick  = (cnt == CNT_MAX);
    assign agree = ~(sync ^ samp);

    // On each tick remember the sample and accept bits that matched the previous one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp <= '0;
            deb  <= '0;
        end else if (tick) begin
            samp <= sync;
            deb  <= (sync & agree) | (deb & ~agree);
        end
    end

endmodule

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: Wishbone GPIO slave with atomic set/clear outputs and per-input edge interrupts.
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int              NIN     = 8,
    parameter int              NOUT    = 8,
    parameter int              DEB_DIV = 16,
    parameter logic [NOUT-1:0] OUT_RST = '0
)
(
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    input  logic [GPIO_AW-1:0] wb_adr_i,
    input  logic [GPIO_DW-1:0] wb_dat_i,
    output logic [GPIO_DW-1:0] wb_dat_o,
    input  logic [1:0]         wb_sel_i,
    input  logic               wb_we_i,
    input  logic               wb_stb_i,
    input  logic               wb_cyc_i,
    output logic               wb_ack_o,
    output logic [NOUT-1:0]    gpio_o,
    input  logic [NIN-1:0]     gpio_i,
    output logic               irq_o
);

    gpio_reg_e          reg_sel;
    logic               req;
    logic               wr;
    logic [GPIO_DW-1:0] wmask;
    logic [GPIO_DW-1:0] wbits;
    logic [GPIO_DW-1:0] rd_data;
    logic               unused_bits;

    logic [NOUT-1:0]    mask_o;
    logic [NOUT-1:0]    bits_o;
    logic [NIN-1:0]     mask_i;
    logic [NIN-1:0]     bits_i;

    logic [NOUT-1:0]    out_q;
    logic [NOUT-1:0]    out_d;
    logic [NIN-1:0]     en_q;
    logic [NIN-1:0]     en_d;
    logic [NIN-1:0]     stat_q;
    logic [NIN-1:0]     stat_d;
    logic [NIN-1:0]     edge_q;
    logic [NIN-1:0]     edge_d;
    logic [NIN-1:0]     w1c;

    logic [NIN-1:0]     deb;
    logic [NIN-1:0]     deb_q;
    logic [NIN-1:0]     rise;
    logic [NIN-1:0]     fall;
    logic [NIN-1:0]     ev;

    gpio_debounce #(
        .N       (NIN),
        .DEB_DIV (DEB_DIV)
    ) u_debounce (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .din   (gpio_i),
        .deb   (deb)
    );

    // A new request is only accepted while no ack is outstanding, giving one ack per transfer.
    assign req     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr      = req & wb_we_i;
    assign reg_sel = gpio_reg_e'(wb_adr_i);

    assign wmask  = byte_mask(wb_sel_i);
    assign wbits  = wb_dat_i & wmask;
    assign mask_o = wmask[NOUT-1:0];
    assign bits_o = wbits[NOUT-1:0];
    assign mask_i = wmask[NIN-1:0];
    assign bits_i = wbits[NIN-1:0];

    // Bits above the implemented widths are deliberately discarded.
    assign unused_bits = ^{wmask, wbits};

    assign rise = deb & ~deb_q;
    assign fall = ~deb & deb_q;
    assign ev   = (rise & ~edge_q) | (fall & edge_q);

    // Next register state from bus writes; hardware edge events override a same-cycle clear.
    always_comb begin
        out_d  = out_q;
        en_d   = en_q;
        edge_d = edge_q;
        w1c    = '0;
        if (wr) begin
            case (reg_sel)
                GPIO_OUT:      out_d  = (out_q & ~mask_o) | bits_o;
                GPIO_OUT_SET:  out_d  = out_q | bits_o;
                GPIO_OUT_CLR:  out_d  = out_q & ~bits_o;
                GPIO_IRQ_EN:   en_d   = (en_q & ~mask_i) | bits_i;
                GPIO_IRQ_STAT: w1c    = bits_i;
                GPIO_EDGE:     edge_d = (edge_q & ~mask_i) | bits_i;
                default:       ;
            endcase
        end
        stat_d = (stat_q & ~w1c) | ev;
    end

    // Read multiplexer, zero-extended to the bus width.
    always_comb begin
        rd_data = '0;
        case (reg_sel)
            GPIO_IN:       rd_data[NIN-1:0]  = deb;
            GPIO_OUT,
            GPIO_OUT_SET,
            GPIO_OUT_CLR:  rd_data[NOUT-1:0] = out_q;
            GPIO_IRQ_EN:   rd_data[NIN-1:0]  = en_q;
            GPIO_IRQ_STAT: rd_data[NIN-1:0]  = stat_q;
            GPIO_EDGE:     rd_data[NIN-1:0]  = edge_q;
            default:       rd_data           = '0;
        endcase
    end

    // Control and status registers.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            out_q  <= OUT_RST;
            en_q   <= '0;
            stat_q <= '0;
            edge_q <= '0;
        end else begin
            out_q  <= out_d;
            en_q   <= en_d;
            stat_q <= stat_d;
            edge_q <= edge_d;
        end
    end

    // One-clock delayed copy of the debounced inputs for edge detection.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            deb_q <= '0;
        end else begin
            deb_q <= deb;
        end
    end

    // Registered ack and read data, captured on the accepting edge.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= req;
            if (req) begin
                wb_dat_o <= rd_data;
            end
        end
    end

    assign gpio_o = out_q;
    assign irq_o  = |(stat_q & en_q);

endmodule

// File: tb/tb_gpio_ctrl.sv
// tb_gpio_ctrl: randomized bench for gpio_ctrl with a behavioural reference model.
module tb_gpio_ctrl;

    localparam int        NIN     = 8;
    localparam int        NOUT    = 8;
    localparam int        DEB_DIV = 4;
    localparam logic [7:0] OUT_RST = 8'hA5;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  adr   = '0;
    logic [15:0] dat_w = '0;
    logic [15:0] dat_r;
    logic [1:0]  sel   = '0;
    logic        we    = 1'b0;
    logic        stb   = 1'b0;
    logic        cyc   = 1'b0;
    logic        ack;
    logic [7:0]  gpio_out;
    logic [7:0]  gpio_in = '0;
    logic        irq;

    int errors = 0;
    int checks = 0;

    // Reference model state: architectural registers plus the input history the
    // debouncer sees (gpio_in as sampled one and two edges ago).
    int m_out, m_en, m_stat, m_edge;
    int m_deb, m_debq, m_samp;
    int m_hist1, m_hist2;
    int m_edges;
    int m_dat;
    bit m_ack;

    gpio_ctrl #(
        .NIN     (NIN),
        .NOUT    (NOUT),
        .DEB_DIV (DEB_DIV),
        .OUT_RST (OUT_RST)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .wb_adr_i  (adr),
        .wb_dat_i  (dat_w),
        .wb_dat_o  (dat_r),
        .wb_sel_i  (sel),
        .wb_we_i   (we),
        .wb_stb_i  (stb),
        .wb_cyc_i  (cyc),
        .wb_ack_o  (ack),
        .gpio_o    (gpio_out),
        .gpio_i    (gpio_in),
        .irq_o     (irq)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int model_read(input int a);
        case (a)
            0:       return m_deb;
            1, 2, 3: return m_out;
            4:       return m_en;
            5:       return m_stat;
            6:       return m_edge;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_out   = int'(OUT_RST);
        m_en    = 0;
        m_stat  = 0;
        m_edge  = 0;
        m_deb   = 0;
        m_debq  = 0;
        m_samp  = 0;
        m_hist1 = 0;
        m_hist2 = 0;
        m_edges = 0;
        m_dat   = 0;
        m_ack   = 1'b0;
    endtask

    task automatic model_step();
        int  sync_v, ev, w1c, mask, wb, a;
        bit  req;
        sync_v = m_hist2;
        // Selected edges are judged on the debounced value versus its previous clock.
        ev = 0;
        for (int b = 0; b < NIN; b++) begin
            if (m_edge[b] == 1'b0 && m_deb[b] == 1'b1 && m_debq[b] == 1'b0) ev |= (1 << b);
            if (m_edge[b] == 1'b1 && m_deb[b] == 1'b0 && m_debq[b] == 1'b1) ev |= (1 << b);
        end
        mask = (sel[1] ? 'hFF00 : 0) | (sel[0] ? 'h00FF : 0);
        wb   = int'(dat_w) & mask;
        a    = int'(adr);
        req  = cyc && stb && !m_ack;
        w1c  = 0;
        if (req) begin
            m_dat = model_read(a);
            if (we) begin
                case (a)
                    1: m_out  = ((m_out & ~mask) | wb) & 'hFF;
                    2: m_out  = (m_out | wb) & 'hFF;
                    3: m_out  = (m_out & ~wb) & 'hFF;
                    4: m_en   = ((m_en & ~mask) | wb) & 'hFF;
                    5: w1c    = wb & 'hFF;
                    6: m_edge = ((m_edge & ~mask) | wb) & 'hFF;
                    default: ;
                endcase
            end
        end
        m_stat = (m_stat & ~w1c) | ev;
        m_ack  = req;
        m_debq = m_deb;
        // Every DEB_DIV-th clock after reset a sample is taken; a bit is accepted
        // once this sample equals the one taken at the previous tick.
        if ((m_edges % DEB_DIV) == DEB_DIV - 1) begin
            for (int b = 0; b < NIN; b++) begin
                if (sync_v[b] == m_samp[b]) begin
                    m_deb = (m_deb & ~(1 << b)) | (sync_v & (1 << b));
                end
            end
            m_samp = sync_v;
        end
        m_edges++;
        m_hist2 = m_hist1;
        m_hist1 = int'(gpio_in);
    endtask

    // Reference model advances on every rising edge.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // Single compare process: DUT outputs against the model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check_output("cmp_gpio_o", 32'(gpio_out), 32'(m_out));
                check_output("cmp_irq_o", 32'(irq), 32'((m_stat & m_en) != 0));
                check_output("cmp_ack", 32'(ack), 32'(m_ack));
                if (m_ack) check_output("cmp_dat_o", 32'(dat_r), 32'(m_dat));
            end
        end
    end

    // One Wishbone transfer; must be entered just after a falling edge.
    task automatic apply_stimulus(input bit w, input int a, input int d, input int s, output int rdata);
        bit got;
        got   = 1'b0;
        cyc   = 1'b1;
        stb   = 1'b1;
        we    = w;
        adr   = a[2:0];
        dat_w = d[15:0];
        sel   = s[1:0];
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (ack) got = 1'b1;
        end
        rdata = int'(dat_r);
        cyc   = 1'b0;
        stb   = 1'b0;
        we    = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("[TB] FAIL bus_timeout: got no ack, expected ack within 4 clocks");
        end
    endtask

    task automatic wait_clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int rd;
        int n_ack;
        bit got;

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check_output("rst_gpio_o", 32'(gpio_out), 32'h00A5);
        check_output("rst_irq_o", 32'(irq), 32'h0);
        apply_stimulus(1'b0, 1, 0, 3, rd);
        check_output("rst_read_out", rd, 32'h00A5);
        apply_stimulus(1'b0, 4, 0, 3, rd);
        check_output("rst_read_en", rd, 32'h0);
        apply_stimulus(1'b0, 5, 0, 3, rd);
        check_output("rst_read_stat", rd, 32'h0);
        apply_stimulus(1'b0, 6, 0, 3, rd);
        check_output("rst_read_edge", rd, 32'h0);

        // Atomic output updates
        apply_stimulus(1'b1, 1, 'h00F0, 3, rd);
        check_output("out_write", 32'(gpio_out), 32'hF0);
        apply_stimulus(1'b1, 2, 'h0003, 3, rd);
        check_output("out_set", 32'(gpio_out), 32'hF3);
        apply_stimulus(1'b1, 3, 'h0080, 3, rd);
        check_output("out_clr", 32'(gpio_out), 32'h73);
        apply_stimulus(1'b1, 1, 'h1234, 2, rd);
        check_output("out_sel_hi_only", 32'(gpio_out), 32'h73);
        apply_stimulus(1'b0, 2, 0, 3, rd);
        check_output("read_out_set_idx", rd, 32'h0073);

        // Short glitch must not reach the debounced value
        gpio_in = 8'h01;
        wait_clocks(3);
        gpio_in = 8'h00;
        wait_clocks(12);
        apply_stimulus(1'b0, 0, 0, 3, rd);
        check_output("glitch_in", rd, 32'h0);

        // Held level appears after debounce; reads track the model every step
        gpio_in = 8'h01;
        for (int i = 0; i < 8; i++) apply_stimulus(1'b0, 0, 0, 3, rd);
        check_output("hold_in", rd, 32'h0001);

        // Edge select and interrupts
        gpio_in = 8'h00;
        wait_clocks(12);
        apply_stimulus(1'b1, 4, 'h0001, 3, rd);
        apply_stimulus(1'b1, 6, 'h0001, 3, rd);
        apply_stimulus(1'b1, 5, 'hFFFF, 3, rd);
        gpio_in = 8'h01;
        wait_clocks(12);
        check_output("rise_no_irq", 32'(irq), 32'h0);
        apply_stimulus(1'b0, 5, 0, 3, rd);
        check_output("rise_stat", rd, 32'h0);
        gpio_in = 8'h00;
        wait_clocks(12);
        check_output("fall_irq", 32'(irq), 32'h1);
        apply_stimulus(1'b0, 5, 0, 3, rd);
        check_output("fall_stat", rd, 32'h0001);
        apply_stimulus(1'b1, 5, 'h0001, 3, rd);
        check_output("w1c_irq", 32'(irq), 32'h0);

        // Clear landing on the same edge as a new falling event
        gpio_in = 8'h01;
        wait_clocks(12);
        gpio_in = 8'h00;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (m_debq[0] == 1'b1 && m_deb[0] == 1'b0) got = 1'b1;
        end
        check_output("collision_found", 32'(got), 32'h1);
        apply_stimulus(1'b1, 5, 'h0001, 3, rd);
        check_output("collision_irq", 32'(irq), 32'h1);
        apply_stimulus(1'b0, 5, 0, 3, rd);
        check_output("collision_stat", rd, 32'h0001);

        // Strobe held for six clocks
        @(negedge clk);
        cyc = 1'b1;
        stb = 1'b1;
        we  = 1'b0;
        adr = 3'd1;
        n_ack = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack) n_ack++;
        end
        cyc = 1'b0;
        stb = 1'b0;
        check_output("held_stb_acks", n_ack, 32'd3);

        // Reset in the middle of a write
        @(negedge clk);
        cyc   = 1'b1;
        stb   = 1'b1;
        we    = 1'b1;
        adr   = 3'd1;
        dat_w = 16'h00FF;
        sel   = 2'b11;
        #2;
        rst_n = 1'b0;
        #1;
        check_output("rst_mid_ack", 32'(ack), 32'h0);
        check_output("rst_mid_gpio", 32'(gpio_out), 32'h00A5);
        @(negedge clk);
        cyc   = 1'b0;
        stb   = 1'b0;
        we    = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        apply_stimulus(1'b0, 1, 0, 3, rd);
        check_output("rst_mid_out", rd, 32'h00A5);

        // Randomized traffic and input activity
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 9) < 6) begin
                apply_stimulus(bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                               int'($urandom_range(0, 65535)), int'($urandom_range(0, 3)), rd);
            end else begin
                gpio_in = 8'($urandom);
                wait_clocks(int'($urandom_range(1, 12)));
            end
        end
        wait_clocks(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
